// File: rtl/ones_frame_accumulator.sv
// ones_frame_accumulator
//
// Sits behind the 12-bit ones-count unit. Each accepted beat carries the
// ones count of one word. Beats are grouped into frames by a last flag.
// For each frame the block accumulates the total ones, the word count and
// the largest per-word count. It then holds one result record on a
// valid/ready output handshake until the record is taken.
//
// A frame is flagged in error in two cases:
//   - it was force-closed at MAX_WORDS beats without a last flag, or
//   - it contained a count above 12. Such a count is clamped to 12 before
//     it is used.
//
// Ports
//   i_clk        clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_in_valid   upstream beat valid
//   o_in_ready   block can accept a beat (low only while a record is held)
//   i_in_cnt     ones count of one 12-bit word, legal range 0..12
//   i_in_last    beat is the final word of its frame
//   o_out_valid  result record valid (registered)
//   i_out_ready  downstream accepts the record
//   o_out_sum    total ones in the frame
//   o_out_words  beats in the frame (1..MAX_WORDS)
//   o_out_max    largest per-word count in the frame
//   o_out_err    frame truncated or contained an illegal count
//
// state  | meaning
// S_IDLE | no beat of the current frame accepted yet
// S_ACC  | frame open, accumulating beats
// S_DONE | record held on the output until downstream takes it

module ones_frame_accumulator #(
    parameter int MAX_WORDS = 256,
    parameter int WCNT_W    = 9,
    parameter int SUM_W     = 12
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [3:0]        i_in_cnt,
    input  logic              i_in_last,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [SUM_W-1:0]  o_out_sum,
    output logic [WCNT_W-1:0] o_out_words,
    output logic [3:0]        o_out_max,
    output logic              o_out_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [WCNT_W-1:0] C_MAX_WORDS = WCNT_W'(MAX_WORDS);
    localparam logic [WCNT_W-1:0] C_ONE       = WCNT_W'(1);

    state_t            r_state;
    logic              r_in_ready;
    logic              r_out_valid;
    logic [SUM_W-1:0]  r_sum;
    logic [WCNT_W-1:0] r_words;
    logic [3:0]        r_max;
    logic              r_err;

    logic              w_accept;
    logic              w_illegal;
    logic [3:0]        w_cnt;
    logic              w_first;
    logic [WCNT_W-1:0] w_words_nxt;
    logic [SUM_W-1:0]  w_sum_nxt;
    logic [3:0]        w_max_nxt;
    logic              w_full;
    logic              w_trunc;
    logic              w_close;
    logic              w_err_nxt;

    assign w_accept  = i_in_valid & r_in_ready;
    assign w_illegal = (i_in_cnt > 4'd12);
    assign w_cnt     = w_illegal ? 4'd12 : i_in_cnt;

    // The first beat of a frame starts from a clean slate. It must not
    // depend on the cleared registers alone, because reset may have left
    // no beat history at all.
    assign w_first     = (r_state == S_IDLE);
    assign w_words_nxt = w_first ? C_ONE : (r_words + C_ONE);
    assign w_sum_nxt   = (w_first ? '0 : r_sum) + {{(SUM_W-4){1'b0}}, w_cnt};
    assign w_max_nxt   = (w_first || (w_cnt > r_max)) ? w_cnt : r_max;

    // A last flag on exactly the MAX_WORDS-th beat is a normal close.
    // Only a missing last at that point counts as truncation.
    assign w_full    = (w_words_nxt == C_MAX_WORDS);
    assign w_trunc   = w_full & ~i_in_last;
    assign w_close   = i_in_last | w_full;
    assign w_err_nxt = (w_first ? 1'b0 : r_err) | w_illegal | w_trunc;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_sum       <= '0;
            r_words     <= '0;
            r_max       <= '0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_ACC: begin
                    if (w_accept) begin
                        r_sum   <= w_sum_nxt;
                        r_words <= w_words_nxt;
                        r_max   <= w_max_nxt;
                        r_err   <= w_err_nxt;
                        if (w_close) begin
                            r_state     <= S_DONE;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_state <= S_ACC;
                        end
                    end
                end
                S_DONE: begin
                    // Ready stays low through the handoff cycle. That gives
                    // the guaranteed dead cycle between frames.
                    if (i_out_ready) begin
                        r_state     <= S_IDLE;
                        r_in_ready  <= 1'b1;
                        r_out_valid <= 1'b0;
                        r_sum       <= '0;
                        r_words     <= '0;
                        r_max       <= '0;
                        r_err       <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_in_ready  = r_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_out_sum   = r_sum;
    assign o_out_words = r_words;
    assign o_out_max   = r_max;
    assign o_out_err   = r_err;

endmodule
